seq_mult_nb: RTL and testbench

Parametrised sequential shift-add multiplier that replaces the hand-wired register/adder/mux multiplier datapath with one self-contained block. It computes an N x N product over N iterations, with a start/done handshake and a per-operation signed/unsigned mode select. The product is held stable for the display path (BCD conversion / seven-segment) until the next operation.

---
 rtl/seq_mult_nb.sv | 87 ++++++++
 tb/tb_seq_mult_nb.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_nb.sv
// Sequential shift-add N x N multiplier with start/done handshake and signed/unsigned mode.
// Signed operands are multiplied as magnitudes and the sign is applied once at the end.
module seq_mult_nb #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           start,
    input  logic           sgn,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] prod
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t        state;
    logic [N-1:0]  acc;
    logic [N-1:0]  mcand;
    logic [N-1:0]  mplr;
    logic [CW-1:0] cnt;
    logic          neg;

    logic [N:0]    sum;
    logic [N-1:0]  abs_a;
    logic [N-1:0]  abs_b;

    // Magnitudes stay N-bit unsigned, so the most negative value maps cleanly to 2^(N-1).
    always_comb begin
        abs_a = a;
        abs_b = b;
        if (sgn && a[N-1]) abs_a = -a;
        if (sgn && b[N-1]) abs_b = -b;
        sum = {1'b0, acc} + (mplr[0] ? {1'b0, mcand} : {(N+1){1'b0}});
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            acc   <= '0;
            mcand <= '0;
            mplr  <= '0;
            cnt   <= '0;
            neg   <= 1'b0;
            done  <= 1'b0;
            prod  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= abs_a;
                        mplr  <= abs_b;
                        neg   <= sgn & (a[N-1] ^ b[N-1]);
                        acc   <= '0;
                        cnt   <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    // Carry out of the add lands in the top of acc after the right shift.
                    acc  <= sum[N:1];
                    mplr <= {sum[0], mplr[N-1:1]};
                    cnt  <= cnt + 1'b1;
                    if (cnt == CW'(N - 1)) state <= FIX;
                end
                FIX: begin
                    prod  <= neg ? -{acc, mplr} : {acc, mplr};
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_nb.sv
// Directed and randomised checks of seq_mult_nb at N=8, plus N=4 and N=16 instances
// compared against a signed/unsigned integer reference product.
module tb_seq_mult_nb;

    logic clk = 1'b0;
    logic clr;

    logic        start8, sgn8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] prod8;

    logic        start4, sgn4, busy4, done4;
    logic [3:0]  a4, b4;
    logic [7:0]  prod4;

    logic        start16, sgn16, busy16, done16;
    logic [15:0] a16, b16;
    logic [31:0] prod16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_mult_nb #(.N(8)) u8 (
        .clk(clk), .clr(clr), .start(start8), .sgn(sgn8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .prod(prod8)
    );

    seq_mult_nb #(.N(4)) u4 (
        .clk(clk), .clr(clr), .start(start4), .sgn(sgn4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .prod(prod4)
    );

    seq_mult_nb #(.N(16)) u16 (
        .clk(clk), .clr(clr), .start(start16), .sgn(sgn16), .a(a16), .b(b16),
        .busy(busy16), .done(done16), .prod(prod16)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic get_done(input int w);
        case (w)
            4:       return done4;
            16:      return done16;
            default: return done8;
        endcase
    endfunction

    function automatic logic get_busy(input int w);
        case (w)
            4:       return busy4;
            16:      return busy16;
            default: return busy8;
        endcase
    endfunction

    function automatic logic [31:0] get_prod(input int w);
        case (w)
            4:       return {24'd0, prod4};
            16:      return prod16;
            default: return {16'd0, prod8};
        endcase
    endfunction

    // Reference product truncated to 2w bits.
    function automatic logic [31:0] model(input int w, input logic s,
                                          input logic [15:0] av, input logic [15:0] bv);
        longint x, y, p;
        logic [63:0] mask;
        x = longint'(av);
        y = longint'(bv);
        if (s && av[w-1]) x = x - (longint'(1) << w);
        if (s && bv[w-1]) y = y - (longint'(1) << w);
        p = x * y;
        mask = (64'd1 << (2 * w)) - 64'd1;
        return 32'(64'(p) & mask);
    endfunction

    task automatic drive(input int w, input logic st, input logic s,
                         input logic [15:0] av, input logic [15:0] bv);
        case (w)
            4:       begin start4  = st; sgn4  = s; a4  = av[3:0]; b4  = bv[3:0]; end
            16:      begin start16 = st; sgn16 = s; a16 = av;      b16 = bv;      end
            default: begin start8  = st; sgn8  = s; a8  = av[7:0]; b8  = bv[7:0]; end
        endcase
    endtask

    task automatic wait_done(input int w, output int edges);
        edges = 0;
        do begin
            tick();
            edges++;
        end while (!get_done(w) && edges < 40);
        if (!get_done(w)) check_output($sformatf("timeout_w%0d", w), {31'd0, get_done(w)}, 32'd1);
    endtask

    task automatic apply_stimulus(input int w, input logic s, input logic [15:0] av,
                                  input logic [15:0] bv, input logic [31:0] exp, input string tag);
        int edges;
        drive(w, 1'b1, s, av, bv);
        tick();
        drive(w, 1'b0, s, av, bv);
        check_output({tag, "_busy_start"}, {31'd0, get_busy(w)}, 32'd1);
        wait_done(w, edges);
        check_output({tag, "_latency"}, edges, w + 1);
        check_output({tag, "_prod"}, get_prod(w), exp);
        check_output({tag, "_busy_done"}, {31'd0, get_busy(w)}, 32'd0);
    endtask

    initial begin
        int e;
        int seen;
        logic [15:0] ra, rb;
        logic        rs;

        clr = 1'b1;
        drive(4, 1'b0, 1'b0, 16'd0, 16'd0);
        drive(8, 1'b0, 1'b0, 16'd0, 16'd0);
        drive(16, 1'b0, 1'b0, 16'd0, 16'd0);
        tick();
        tick();
        clr = 1'b0;
        check_output("reset_prod", {16'd0, prod8}, 32'd0);
        check_output("reset_busy", {31'd0, busy8}, 32'd0);
        check_output("reset_done", {31'd0, done8}, 32'd0);
        check_output("reset_prod16", prod16, 32'd0);
        tick();

        apply_stimulus(8, 1'b0, 16'd13, 16'd11, 32'h008F, "u13x11");
        apply_stimulus(8, 1'b1, 16'h00FB, 16'h0007, 32'hFFDD, "s_m5x7");
        apply_stimulus(8, 1'b1, 16'h0080, 16'h0080, 32'h4000, "s_m128sq");
        apply_stimulus(8, 1'b0, 16'h00FF, 16'h00FF, 32'hFE01, "u255sq");
        apply_stimulus(8, 1'b0, 16'h0000, 16'h00FF, 32'h0000, "u0x255");

        // Start pulse and operand change while busy must be ignored.
        drive(8, 1'b1, 1'b0, 16'd12, 16'd10);
        tick();
        drive(8, 1'b0, 1'b0, 16'd12, 16'd10);
        tick();
        tick();
        tick();
        drive(8, 1'b1, 1'b1, 16'd3, 16'd3);
        tick();
        drive(8, 1'b0, 1'b1, 16'd99, 16'd3);
        e = 4;
        seen = 0;
        while (!done8 && e < 40) begin
            tick();
            e++;
        end
        check_output("ignore_latency", e, 9);
        check_output("ignore_prod", {16'd0, prod8}, 32'h0078);
        // Back-to-back start in the done cycle.
        drive(8, 1'b1, 1'b0, 16'd3, 16'd3);
        tick();
        drive(8, 1'b0, 1'b0, 16'd3, 16'd3);
        check_output("b2b_done_pulse", {31'd0, done8}, 32'd0);
        check_output("b2b_busy", {31'd0, busy8}, 32'd1);
        wait_done(8, e);
        check_output("b2b_latency", e + 1, 10);
        check_output("b2b_prod", {16'd0, prod8}, 32'h0009);
        tick();

        // Abort with clr mid-operation.
        drive(8, 1'b1, 1'b0, 16'd12, 16'd10);
        tick();
        drive(8, 1'b0, 1'b0, 16'd12, 16'd10);
        for (int i = 1; i <= 4; i++) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check_output("abort_busy", {31'd0, busy8}, 32'd0);
        check_output("abort_done", {31'd0, done8}, 32'd0);
        check_output("abort_prod", {16'd0, prod8}, 32'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            seen += int'(done8);
        end
        check_output("abort_no_done", seen, 0);
        apply_stimulus(8, 1'b0, 16'd7, 16'd6, 32'h002A, "u7x6");

        // Randomised sweeps at the other widths.
        for (int i = 0; i < 6; i++) begin
            ra = 16'($urandom_range(0, 15));
            rb = 16'($urandom_range(0, 15));
            rs = 1'($urandom_range(0, 1));
            apply_stimulus(4, rs, ra, rb, model(4, rs, ra, rb), $sformatf("n4_%0d", i));
        end
        apply_stimulus(4, 1'b1, 16'h0008, 16'h0008, 32'h0040, "n4_min_sq");
        for (int i = 0; i < 6; i++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 65535));
            rs = 1'($urandom_range(0, 1));
            apply_stimulus(16, rs, ra, rb, model(16, rs, ra, rb), $sformatf("n16_%0d", i));
        end
        apply_stimulus(16, 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, "n16_max_sq");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
